// File: rtl/one_cold_scanner.sv
// one_cold_scanner: drives N active-low select lines, exactly one low at a time.
// A prescaler rotates the active line. Software can freeze the rotation with
// hold or jump to a chosen line with force_valid/force_sel.
// Optional anti-ghosting blank gap after each line change: define ONE_COLD_BLANK_EN.
module one_cold_scanner #(
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int DIV_W = 16,
  parameter int BLANK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  input  logic             force_valid,
  input  logic [SEL_W-1:0] force_sel,
  output logic [N-1:0]     out,
  output logic [SEL_W-1:0] sel,
  output logic             step,
  output logic             wrap,
  output logic             force_err
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     out_q, out_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  // act_q is low while parked; the first enabled edge only shows line 0.
  logic             act_q, act_d;

  logic force_ok;
  logic last_line;

  function automatic logic [N-1:0] one_cold(input logic [SEL_W-1:0] s);
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) begin
      f[i] = (int'(s) != i);
    end
    return f;
  endfunction

  assign force_ok  = force_valid && (int'(force_sel) < N);
  assign last_line = (int'(sel_q) == N - 1);

`ifdef ONE_COLD_BLANK_EN
  localparam int BW = (BLANK < 1) ? 1 : $clog2(BLANK + 1);

  logic [BW-1:0]  blank_q, blank_d;
  logic [BW-1:0]  blank_len;
  logic [DIV_W:0] div_p1;

  // Blank length is min(BLANK, div+1) so short dwells never blank past the next change.
  always_comb begin
    div_p1 = {1'b0, div} + {{DIV_W{1'b0}}, 1'b1};
    if (div_p1 < (DIV_W+1)'(BLANK)) begin
      blank_len = div_p1[BW-1:0];
    end else begin
      blank_len = BW'(BLANK);
    end
  end
`endif

  // Next-state: en, then force, then hold, then prescaler advance.
  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    act_d  = act_q;
    if (!en) begin
      cnt_d = '0;
      sel_d = '0;
      act_d = 1'b0;
    end else begin
      act_d = 1'b1;
      err_d = force_valid && !force_ok;
      if (force_ok) begin
        sel_d  = force_sel;
        cnt_d  = '0;
        step_d = 1'b1;
      end else if (!act_q) begin
        cnt_d = '0;
        sel_d = '0;
      end else if (hold) begin
        cnt_d = cnt_q;
      end else if (cnt_q >= div) begin
        cnt_d  = '0;
        sel_d  = last_line ? '0 : sel_q + SEL_W'(1);
        step_d = 1'b1;
        wrap_d = last_line;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

`ifdef ONE_COLD_BLANK_EN
  // Output with blank gap; hold freezes both the gap counter and the lines.
  always_comb begin
    blank_d = blank_q;
    out_d   = one_cold(sel_d);
    if (!en) begin
      blank_d = '0;
      out_d   = '1;
    end else if (step_d) begin
      if (blank_len == '0) begin
        blank_d = '0;
      end else begin
        blank_d = blank_len - BW'(1);
        out_d   = '1;
      end
    end else if (act_q && hold) begin
      out_d = out_q;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BW'(1);
      out_d   = '1;
    end
  end

  // Blank counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end
`else
  // Output tracks the next line index directly.
  always_comb begin
    out_d = en ? one_cold(sel_d) : '1;
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      out_q  <= '1;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      out_q  <= out_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      act_q  <= act_d;
    end
  end

  assign out       = out_q;
  assign sel       = sel_q;
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign force_err = err_q;

endmodule
